// File: rtl/wb_io_arbiter.sv
// Round-robin Wishbone arbiter: several masters share one wb_io master port.
// Ownership is held for a whole bus cycle, and a per-transfer watchdog ends hung accesses with ERR.
module wb_io_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
    input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
    input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
    input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
    output logic [32*NUM_MASTERS-1:0] wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS-1:0]    wbm_rty_o,
    output logic [31:0]               wbs_adr_o,
    output logic [31:0]               wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [31:0]               wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int unsigned OW       = $clog2(NUM_MASTERS);
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [OW-1:0] cand;
    logic [15:0]   wdog_q, wdog_d;
    logic          own_cyc, own_stb, slv_resp, wd_fire, found;

    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
    assign slv_resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;

    // Slave-side mux and response routing; everything stays zero while idle.
    always_comb begin
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        grant_o   = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        wd_fire   = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (state_q == OWN && owner_q == OW'(i)) begin
                own_cyc   = wbm_cyc_i[i];
                own_stb   = wbm_stb_i[i];
                wbs_adr_o = wbm_adr_i[i*32 +: 32];
                wbs_dat_o = wbm_dat_i[i*32 +: 32];
                wbs_sel_o = wbm_sel_i[i*4 +: 4];
                wbs_we_o  = wbm_we_i[i];
                wbs_cti_o = wbm_cti_i[i*3 +: 3];
                wbs_bte_o = wbm_bte_i[i*2 +: 2];
                grant_o[i] = 1'b1;
                wd_fire   = wbm_stb_i[i] & ~slv_resp & (wdog_q == WD_LIMIT);
                wbm_ack_o[i] = wbs_ack_i;
                wbm_err_o[i] = wbs_err_i | wd_fire;
                wbm_rty_o[i] = wbs_rty_i;
            end
        end
        wbs_cyc_o = own_cyc;
        wbs_stb_o = own_stb & ~wd_fire;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wdog_d  = '0;
        found   = 1'b0;
        cand    = '0;
        case (state_q)
            IDLE: begin
                // Rotating search starts just above the previous owner.
                for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
                    cand = OW'((32'(last_q) + k) % NUM_MASTERS);
                    if (!found && wbm_cyc_i[cand]) begin
                        found   = 1'b1;
                        owner_d = cand;
                    end
                end
                if (found) state_d = OWN;
            end
            OWN: begin
                if (own_stb && !slv_resp && !wd_fire) wdog_d = wdog_q + 16'd1;
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NUM_MASTERS - 1);
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Bench for wb_io_arbiter: directed table, hand-written multi-cycle sequences,
// and randomized traffic checked against a cycle-level arbitration model.
module tb_wb_io_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] m_adr, m_dat;
    logic [7:0]  m_sel;
    logic [1:0]  m_we, m_cyc, m_stb;
    logic [5:0]  m_cti;
    logic [3:0]  m_bte;
    logic [63:0] d_dat;
    logic [1:0]  d_ack, d_err, d_rty, grant;
    logic [31:0] s_adr, s_dat, s_dat_in;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: owner index (-1 = nobody), previous owner, watchdog count.
    int mo, ml, mc;
    bit m_fire;

    wb_io_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_dat_o(d_dat), .wbm_ack_o(d_ack), .wbm_err_o(d_err), .wbm_rty_o(d_rty),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
        .wbs_dat_i(s_dat_in), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [1:0]  eg, ea, ee, er;
        logic        ecyc, estb, ewe;
        logic [31:0] eadr, edat;
        logic [3:0]  esel;
        logic [2:0]  ecti;
        logic [1:0]  ebte;
        bit          resp;
        eg = '0; ea = '0; ee = '0; er = '0;
        ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
        eadr = '0; edat = '0; esel = '0; ecti = '0; ebte = '0;
        m_fire = 1'b0;
        resp = s_ack | s_err | s_rty;
        for (int i = 0; i < N; i++) begin
            if (i == mo) begin
                m_fire = m_stb[i] && (mc == TO - 1) && !resp;
                eg[i] = 1'b1;
                ecyc  = m_cyc[i];
                estb  = m_stb[i] && !m_fire;
                ewe   = m_we[i];
                eadr  = m_adr[i*32 +: 32];
                edat  = m_dat[i*32 +: 32];
                esel  = m_sel[i*4 +: 4];
                ecti  = m_cti[i*3 +: 3];
                ebte  = m_bte[i*2 +: 2];
                ea[i] = s_ack;
                ee[i] = s_err | m_fire;
                er[i] = s_rty;
            end
        end
        chk("grant_o",   32'(grant), 32'(eg));
        chk("wbs_cyc_o", 32'(s_cyc), 32'(ecyc));
        chk("wbs_stb_o", 32'(s_stb), 32'(estb));
        chk("wbs_we_o",  32'(s_we),  32'(ewe));
        chk("wbs_adr_o", s_adr, eadr);
        chk("wbs_dat_o", s_dat, edat);
        chk("wbs_sel_o", 32'(s_sel), 32'(esel));
        chk("wbs_cti_o", 32'(s_cti), 32'(ecti));
        chk("wbs_bte_o", 32'(s_bte), 32'(ebte));
        chk("wbm_ack_o", 32'(d_ack), 32'(ea));
        chk("wbm_err_o", 32'(d_err), 32'(ee));
        chk("wbm_rty_o", 32'(d_rty), 32'(er));
        chk("wbm_dat_o0", d_dat[31:0], s_dat_in);
        chk("wbm_dat_o1", d_dat[63:32], s_dat_in);
    endtask

    task automatic step_model();
        bit resp;
        int idx;
        resp = s_ack | s_err | s_rty;
        if (rst) begin
            mo = -1; ml = N - 1; mc = 0;
        end else if (mo < 0) begin
            mc = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (ml + k) % N;
                if (mo < 0 && m_cyc[idx]) mo = idx;
            end
        end else begin
            if (!m_stb[mo] || resp || m_fire) mc = 0;
            else mc = mc + 1;
            if (!m_cyc[mo]) begin
                ml = mo;
                mo = -1;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        step_model();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] cyc;
        logic [1:0] stb;
        logic       ack;
        logic [1:0] g;
        logic       c;
        logic       s;
        logic [1:0] a;
    } vec_t;

    vec_t tv[24];

    initial begin
        int n_a0, n_a1, n_err, err_k;
        logic stb_at;

        tv[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tv[1]  = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tv[2]  = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00};
        tv[3]  = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00};
        tv[4]  = '{1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
        tv[5]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00};
        tv[6]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tv[7]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tv[8]  = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tv[9]  = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
        tv[10] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00};
        tv[11] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tv[12] = '{1'b0, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10};
        tv[13] = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00};
        tv[14] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tv[15] = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
        tv[16] = '{1'b0, 2'b10, 2'b10, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00};
        tv[17] = '{1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tv[18] = '{1'b0, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10};
        tv[19] = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00};
        tv[20] = '{1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
        tv[21] = '{1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01};
        tv[22] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00};
        tv[23] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};

        rst = 1'b1;
        m_adr = {32'h0000_2080, 32'h0000_1040};
        m_dat = {32'h2222_2222, 32'h1111_1111};
        m_sel = 8'hFF; m_we = 2'b00; m_cyc = 2'b00; m_stb = 2'b00;
        m_cti = '0; m_bte = '0;
        s_dat_in = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mo = -1; ml = N - 1; mc = 0;

        // Directed table: single read, simultaneous requests, alternation.
        for (int r = 0; r < 24; r++) begin
            rst = tv[r].rst; m_cyc = tv[r].cyc; m_stb = tv[r].stb; s_ack = tv[r].ack;
            s_dat_in = 32'hCAFE_0000 + 32'(r);
            sample();
            chk($sformatf("tbl%0d_grant", r), 32'(grant), 32'(tv[r].g));
            chk($sformatf("tbl%0d_cyc", r),   32'(s_cyc), 32'(tv[r].c));
            chk($sformatf("tbl%0d_stb", r),   32'(s_stb), 32'(tv[r].s));
            chk($sformatf("tbl%0d_ack", r),   32'(d_ack), 32'(tv[r].a));
            chk($sformatf("tbl%0d_err", r),   32'(d_err), 32'd0);
            advance();
        end
        rst = 1'b0; s_ack = 1'b0;

        // Incrementing burst by M0 while M1 waits.
        n_a0 = 0; n_a1 = 0;
        m_cyc = 2'b01; m_stb = 2'b01; m_cti[2:0] = 3'b010; m_adr[31:0] = 32'h3000;
        sample(); advance();
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int b = 0; b < 4; b++) begin
            m_cti[2:0] = (b == 3) ? 3'b111 : 3'b010;
            m_adr[31:0] = 32'h3000 + 32'(4 * b);
            s_ack = 1'b1;
            sample();
            n_a0 += int'(d_ack[0]); n_a1 += int'(d_ack[1]);
            chk("burst_grant", 32'(grant), 32'h1);
            chk("burst_cti", 32'(s_cti), (b == 3) ? 32'h7 : 32'h2);
            advance();
        end
        m_cyc = 2'b10; m_stb = 2'b10; s_ack = 1'b0;
        sample(); n_a1 += int'(d_ack[1]); advance();
        sample(); chk("burst_gap_grant", 32'(grant), 32'h0); advance();
        sample(); chk("burst_m1_grant", 32'(grant), 32'h2); advance();
        m_cyc = 2'b00; m_stb = 2'b00;
        sample(); advance();
        chk("burst_acks_m0", 32'(n_a0), 32'd4);
        chk("burst_acks_m1", 32'(n_a1), 32'd0);

        // Watchdog on an unanswered access.
        n_err = 0; err_k = -1; stb_at = 1'b1;
        m_cyc = 2'b01; m_stb = 2'b01; m_adr[31:0] = 32'h5000; m_cti[2:0] = 3'b000;
        sample(); advance();
        for (int k = 0; k < 12; k++) begin
            sample();
            if (d_err[0]) begin
                n_err++; err_k = k; stb_at = s_stb;
            end
            advance();
        end
        chk("wd_err_count", 32'(n_err), 32'd1);
        chk("wd_err_cycle", 32'(err_k), 32'd7);
        chk("wd_stb_low", 32'(stb_at), 32'd0);
        m_cyc = 2'b00; m_stb = 2'b00;
        sample(); advance();
        sample(); advance();

        // Reset in the middle of a burst.
        m_cyc = 2'b01; m_stb = 2'b01; m_cti[2:0] = 3'b010;
        sample(); advance();
        s_ack = 1'b1;
        sample(); advance();
        sample(); advance();
        rst = 1'b1; m_cyc = 2'b11; m_stb = 2'b11;
        sample(); advance();
        rst = 1'b0;
        sample();
        chk("rst_cyc", 32'(s_cyc), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(d_ack), 32'd0);
        chk("rst_err", 32'(d_err), 32'd0);
        advance();
        sample(); chk("rst_first_grant", 32'(grant), 32'h1); advance();
        m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0;
        sample(); advance();
        sample(); advance();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i] = m_cyc[i] && ($urandom_range(0, 3) != 0);
            end
            m_adr = {$urandom, $urandom};
            m_dat = {$urandom, $urandom};
            m_sel = 8'($urandom);
            m_we  = 2'($urandom);
            m_cti = 6'($urandom);
            m_bte = 4'($urandom);
            s_dat_in = $urandom;
            s_ack = ($urandom_range(0, 9) == 0);
            s_err = ($urandom_range(0, 29) == 0);
            s_rty = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
